inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
Parameters
REQ-001 DEPTH, 16, number of instruction entries; SHALL be a power of two, at least 2.
REQ-002 PTR_W, 4, pointer width; SHALL equal log2(DEPTH).

Ports
REQ-003 clk_in  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 rdy_in  in  1  global ready; when low, the block SHALL hold all state.
REQ-006 flush  in  1  misprediction rollback; discards all queued entries.
REQ-007 push_valid  in  1  fetcher offers one instruction this cycle.
REQ-008 push_ins  in  32  fetched instruction word.
REQ-009 push_pc  in  32  PC of the fetched instruction.
REQ-010 push_pred_pc  in  32  predicted next PC of the fetched instruction.
REQ-011 iq_full  out  1  SHALL be high exactly when count == DEPTH.
REQ-012 decode_flag  out  1  head entry valid for the decoder.
REQ-013 ins  out  32  head instruction word.
REQ-014 ins_pc  out  32  head PC.
REQ-015 ins_pred_pc  out  32  head predicted PC.
REQ-016 decode_ok  in  1  decoder accepted the head this cycle; the decoder drives it combinationally.
REQ-017 count  out  PTR_W+1  number of valid entries, 0..DEPTH.

Function
REQ-018 Storage SHALL be a circular buffer with head pointer, tail pointer and count registers; both pointers wrap from DEPTH-1 to 0.
REQ-019 decode_flag SHALL equal (count != 0) && rdy_in && !flush, combinationally.
REQ-020 ins, ins_pc and ins_pred_pc SHALL drive the entry at head combinationally.
  - Their value is don't-care while decode_flag is 0.
REQ-021 Push SHALL occur when push_valid && !iq_full && rdy_in && !flush.
  - The entry is written at tail.
  - tail advances by 1.
REQ-022 Pop SHALL occur when decode_flag && decode_ok; head advances by 1.
REQ-023 Count update on each edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
REQ-024 iq_full SHALL be evaluated from the registered count.
  - When full, push SHALL be refused even if a pop occurs in the same cycle.
  - A refused push_valid is dropped; the fetcher keeps it and retries.
REQ-025 When empty, decode_ok SHALL be ignored and SHALL NOT cause a pop.
REQ-026 Flush SHALL take priority over push and pop.
  - At the next edge, head, tail and count are set to 0.
  - decode_flag is 0 during the flush cycle.
REQ-027 When rdy_in is low, pointers, count and storage SHALL hold.
  - flush is ignored while rdy_in is low.
REQ-028 Latency:
  - An entry pushed at edge N SHALL present decode_flag=1 in the cycle after edge N.
  - There is no bypass from push_* to the outputs.
REQ-029 Order SHALL be strictly FIFO; there is no reordering and no duplication.

Reset
REQ-030 On rst_n low, immediately and independent of clk_in:
  - head, tail and count SHALL be 0.
  - iq_full and decode_flag SHALL be 0.
REQ-031 Storage contents need not be reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries, including a push or pop in progress that cycle.

Verification
REQ-033 Basic FIFO: push ins=0x00500093 pc=0x0 pred=0x4, then ins=0x00100113 pc=0x4 pred=0x8, decode_ok=1 -> decoder sees the two entries in order on consecutive cycles, then decode_flag=0 and count=0.
REQ-034 Fill: push 16 entries with decode_ok=0 -> count=16, iq_full=1; a 17th push is dropped; decode_ok=1 for one cycle -> count=15, iq_full=0.
REQ-035 Full plus simultaneous push and pop: with count=16, push_valid=1 and decode_ok=1 -> count=15 and the pushed word is absent; with count=5, both asserted -> count stays 5 and the new word appears last.
REQ-036 Flush: count=7, then flush=1 together with push_valid=1 and decode_ok=1 -> decode_flag=0 that cycle, count=0 next cycle, nothing pushed.
REQ-037 Wrap-around: 40 pushes and pops interleaved at random -> output sequence matches a reference queue model, pointers wrap correctly.
REQ-038 Stall and reset: rdy_in=0 for 3 cycles with push_valid and decode_ok high -> count unchanged, decode_flag=0; rst_n low mid-stream -> count=0 without waiting for a clock edge.

Source files
------------

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side push port and decode-side head port of the instruction queue.
interface inst_queue_if #(parameter int PTR_W = 4);
    logic             rdy_in;
    logic             flush;
    logic             push_valid;
    logic [31:0]      push_ins;
    logic [31:0]      push_pc;
    logic [31:0]      push_pred_pc;
    logic             iq_full;
    logic             decode_flag;
    logic [31:0]      ins;
    logic [31:0]      ins_pc;
    logic [31:0]      ins_pred_pc;
    logic             decode_ok;
    logic [PTR_W:0]   count;
    modport master (
        output rdy_in, flush, push_valid, push_ins, push_pc, push_pred_pc, decode_ok,
        input  iq_full, decode_flag, ins, ins_pc, ins_pred_pc, count
    );
    modport slave (
        input  rdy_in, flush, push_valid, push_ins, push_pc, push_pred_pc, decode_ok,
        output iq_full, decode_flag, ins, ins_pc, ins_pred_pc, count
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: circular instruction FIFO between fetch and decode with flush rollback.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input logic          clk_in,
    input logic          rst_n,
    inst_queue_if.slave  bus
);
    logic [95:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   r_count;
    logic             w_push, w_pop;
    assign bus.count       = r_count;
    assign bus.iq_full     = r_count == (PTR_W+1)'(DEPTH);
    assign bus.decode_flag = (r_count != '0) && bus.rdy_in && !bus.flush;
    assign {bus.ins, bus.ins_pc, bus.ins_pred_pc} = r_mem[r_head];
    // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    assign w_push = bus.push_valid && !bus.iq_full && bus.rdy_in && !bus.flush;
    assign w_pop  = bus.decode_flag && bus.decode_ok;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.rdy_in && bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_tail] <= {bus.push_ins, bus.push_pc, bus.push_pred_pc};
    end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized checks of inst_queue against a queue-based reference model.
module tb_inst_queue;
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [95:0] q[$];

    inst_queue_if #(.PTR_W(4)) bus();
    inst_queue #(.DEPTH(16), .PTR_W(4)) dut (.clk_in(clk_in), .rst_n(rst_n), .bus(bus));

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [95:0] rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic pv, input logic dok, input logic rdy, input logic fl, input logic [95:0] d);
        bus.push_valid = pv;
        bus.decode_ok  = dok;
        bus.rdy_in     = rdy;
        bus.flush      = fl;
        {bus.push_ins, bus.push_pc, bus.push_pred_pc} = d;
        #1;
    endtask

    // Reference: a plain queue of at most 16 entries, updated from the inputs seen at the edge.
    task automatic tick();
        bit psh, pp, fl;
        logic [95:0] d;
        d   = {bus.push_ins, bus.push_pc, bus.push_pred_pc};
        fl  = bus.rdy_in && bus.flush;
        psh = bus.push_valid && q.size() < 16 && bus.rdy_in && !bus.flush;
        pp  = q.size() != 0 && bus.rdy_in && !bus.flush && bus.decode_ok;
        @(posedge clk_in);
        if (fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (psh) q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 0, '0);
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.iq_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.iq_full); end
        checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL reset_df: got %b want 0", bus.decode_flag); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive(1, 1, 1, 0, {32'h00500093, 32'h0, 32'h4});
        checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL basic_df0: got %b want 0", bus.decode_flag); end
        tick();
        drive(1, 1, 1, 0, {32'h00100113, 32'h4, 32'h8});
        checks++; if (bus.decode_flag !== 1'b1 || {bus.ins, bus.ins_pc, bus.ins_pred_pc} !== {32'h00500093, 32'h0, 32'h4}) begin
            errors++; $display("FAIL basic_first: got df=%b %h want df=1 00500093/0/4", bus.decode_flag, {bus.ins, bus.ins_pc, bus.ins_pred_pc});
        end
        tick();
        drive(0, 1, 1, 0, '0);
        checks++; if (bus.decode_flag !== 1'b1 || {bus.ins, bus.ins_pc, bus.ins_pred_pc} !== {32'h00100113, 32'h4, 32'h8}) begin
            errors++; $display("FAIL basic_second: got df=%b %h want df=1 00100113/4/8", bus.decode_flag, {bus.ins, bus.ins_pc, bus.ins_pred_pc});
        end
        tick();
        checks++; if (bus.decode_flag !== 1'b0 || bus.count !== 5'd0) begin
            errors++; $display("FAIL basic_empty: got df=%b count=%0d want df=0 count=0", bus.decode_flag, bus.count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin drive(1, 0, 1, 0, rnd()); tick(); end
        drive(0, 0, 1, 0, '0);
        checks++; if (bus.count !== 5'd16 || bus.iq_full !== 1'b1) begin
            errors++; $display("FAIL fill_full: got count=%0d full=%b want 16/1", bus.count, bus.iq_full);
        end
        drive(1, 0, 1, 0, rnd());
        tick();
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_drop17: got %0d want 16", bus.count); end
        drive(0, 1, 1, 0, '0);
        tick();
        checks++; if (bus.count !== 5'd15 || bus.iq_full !== 1'b0) begin
            errors++; $display("FAIL fill_pop: got count=%0d full=%b want 15/0", bus.count, bus.iq_full);
        end
        repeat (q.size()) begin
            drive(0, 1, 1, 0, '0);
            checks++; if (bus.decode_flag !== 1'b1 || {bus.ins, bus.ins_pc, bus.ins_pred_pc} !== q[0]) begin
                errors++; $display("FAIL fill_drain: got df=%b %h want df=1 %h", bus.decode_flag, {bus.ins, bus.ins_pc, bus.ins_pred_pc}, q[0]);
            end
            tick();
        end
    endtask

    task automatic test_full_pushpop();
        logic [95:0] w;
        for (int i = 0; i < 16; i++) begin drive(1, 0, 1, 0, rnd()); tick(); end
        w = rnd();
        drive(1, 1, 1, 0, w);
        tick();
        checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL fullpp_count: got %0d want 15", bus.count); end
        repeat (q.size()) begin
            drive(0, 1, 1, 0, '0);
            checks++; if ({bus.ins, bus.ins_pc, bus.ins_pred_pc} !== q[0] || {bus.ins, bus.ins_pc, bus.ins_pred_pc} === w) begin
                errors++; $display("FAIL fullpp_drain: got %h want %h", {bus.ins, bus.ins_pc, bus.ins_pred_pc}, q[0]);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin drive(1, 0, 1, 0, rnd()); tick(); end
        w = rnd();
        drive(1, 1, 1, 0, w);
        tick();
        checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL pp5_count: got %0d want 5", bus.count); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, '0);
            checks++; if ({bus.ins, bus.ins_pc, bus.ins_pred_pc} !== q[0]) begin
                errors++; $display("FAIL pp5_drain: got %h want %h", {bus.ins, bus.ins_pc, bus.ins_pred_pc}, q[0]);
            end
            if (i == 4) begin
                checks++; if ({bus.ins, bus.ins_pc, bus.ins_pred_pc} !== w) begin
                    errors++; $display("FAIL pp5_last: got %h want %h", {bus.ins, bus.ins_pc, bus.ins_pred_pc}, w);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin drive(1, 0, 1, 0, rnd()); tick(); end
        drive(0, 0, 1, 0, '0);
        checks++; if (bus.count !== 5'd7) begin errors++; $display("FAIL flush_pre: got %0d want 7", bus.count); end
        drive(1, 1, 1, 1, rnd());
        checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL flush_df: got %b want 0", bus.decode_flag); end
        tick();
        drive(0, 0, 1, 0, '0);
        checks++; if (bus.count !== 5'd0 || bus.decode_flag !== 1'b0) begin
            errors++; $display("FAIL flush_after: got count=%0d df=%b want 0/0", bus.count, bus.decode_flag);
        end
    endtask

    task automatic test_wrap();
        int pushes = 0;
        logic pv, dok;
        for (int c = 0; c < 400 && pushes < 40; c++) begin
            pv  = 1'($urandom_range(0, 1));
            dok = 1'($urandom_range(0, 1));
            drive(pv, dok, 1, 0, rnd());
            checks++; if (bus.decode_flag !== (q.size() != 0) || bus.iq_full !== (q.size() == 16) || bus.count !== 5'(q.size())) begin
                errors++; $display("FAIL wrap_state: got df=%b full=%b count=%0d want size %0d", bus.decode_flag, bus.iq_full, bus.count, q.size());
            end
            if (q.size() != 0) begin
                checks++; if ({bus.ins, bus.ins_pc, bus.ins_pred_pc} !== q[0]) begin
                    errors++; $display("FAIL wrap_head: got %h want %h", {bus.ins, bus.ins_pc, bus.ins_pred_pc}, q[0]);
                end
            end
            if (pv && q.size() < 16) pushes++;
            tick();
        end
        checks++; if (pushes < 40) begin errors++; $display("FAIL wrap_budget: got %0d pushes want 40", pushes); end
        repeat (q.size()) begin
            drive(0, 1, 1, 0, '0);
            checks++; if ({bus.ins, bus.ins_pc, bus.ins_pred_pc} !== q[0]) begin
                errors++; $display("FAIL wrap_drain: got %h want %h", {bus.ins, bus.ins_pc, bus.ins_pred_pc}, q[0]);
            end
            tick();
        end
    endtask

    task automatic test_stall_reset();
        for (int i = 0; i < 3; i++) begin drive(1, 0, 1, 0, rnd()); tick(); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1'(i == 1), rnd());
            checks++; if (bus.decode_flag !== 1'b0) begin errors++; $display("FAIL stall_df: got %b want 0", bus.decode_flag); end
            tick();
            checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL stall_count: got %0d want 3", bus.count); end
        end
        drive(0, 0, 1, 0, '0);
        checks++; if (bus.decode_flag !== 1'b1 || {bus.ins, bus.ins_pc, bus.ins_pred_pc} !== q[0]) begin
            errors++; $display("FAIL stall_head: got df=%b %h want df=1 %h", bus.decode_flag, {bus.ins, bus.ins_pc, bus.ins_pred_pc}, q[0]);
        end
        drive(1, 1, 1, 0, rnd());
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.count !== 5'd0 || bus.decode_flag !== 1'b0 || bus.iq_full !== 1'b0) begin
            errors++; $display("FAIL async_reset: got count=%0d df=%b full=%b want 0/0/0", bus.count, bus.decode_flag, bus.iq_full);
        end
        q.delete();
        #2 rst_n = 1'b1;
        drive(0, 1, 1, 0, '0);
        tick();
        checks++; if (bus.count !== 5'd0 || bus.decode_flag !== 1'b0) begin
            errors++; $display("FAIL post_reset: got count=%0d df=%b want 0/0", bus.count, bus.decode_flag);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_full_pushpop();
        test_flush();
        test_wrap();
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
